// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and widths for handshaked pipeline stages
package pipe_pkg;

  // Occupancy of a pipeline stage: nothing, main only, main plus skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Decode-to-execute control bundle
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
    logic [1:0] branch_jump;
    logic [1:0] alu_src;
    logic [2:0] mem_size;
    logic       mem_unsigned;
  } id_ex_ctrl_t;

  // Execute-to-memory control bundle
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [2:0] mem_size;
    logic       mem_unsigned;
  } ex_mem_ctrl_t;

  // Memory-to-writeback control bundle
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mem_wb_ctrl_t;

  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - event counter that adds 0..3 per cycle and sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH:0] sum;

  // One extra bit catches the carry that signals saturation
  always_comb begin
    sum = {1'b0, count} + {{(CNT_WIDTH - 1){1'b0}}, inc};
  end

  // Accumulate, clamping to all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (sum[CNT_WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline register with skid buffer, flush and event counters
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int CTRL_WIDTH = ID_EX_CTRL_W,
  parameter bit SKID_EN    = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  pipe_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, skid_data_q;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, skid_ctrl_q;
  logic                  xfer_in, xfer_out;
  logic                  load_main, load_skid, skid_to_main;
  logic [1:0]            held_cnt, flush_inc, stall_inc;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

  // With a skid slot, ready depends only on held state; without one it looks through to out_ready
  if (SKID_EN) begin : g_skid_ready
    assign in_ready = !rst && (state_q != FULL);
  end else begin : g_reg_ready
    assign in_ready = !rst && (!out_valid || out_ready);
  end

  // Next-state and register-steering decisions; flush overrides every move
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    held_cnt     = 2'd0;
    case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        held_cnt = 2'd1;
        if (xfer_in && xfer_out) begin
          load_main = 1'b1;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end else if (xfer_in && SKID_EN) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end
      end
      FULL: begin
        held_cnt = 2'd2;
        if (xfer_out) begin
          state_d      = BUSY;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // Squashed entries: held ones not leaving this cycle, plus whatever is offered at the input
  assign flush_inc = flush ? (held_cnt - {1'b0, xfer_out} + {1'b0, in_valid}) : 2'd0;
  assign stall_inc = {1'b0, out_valid && !out_ready && !flush};

  // State plus main/skid payload; flush clears control but leaves data in place
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (skid_to_main) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
      if (flush) begin
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
      end
    end
  end

  pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - scoreboard bench for pipe_stage
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [95:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [95:0] out_data;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_in_ready, s_out_valid;
  logic [95:0] s_out_data;
  logic [15:0] s_out_ctrl;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [95:0] d;
    logic [15:0] c;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipe_stage u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  pipe_stage #(.CNT_WIDTH(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_ctrl  (s_out_ctrl),
    .stall_cnt (s_stall_cnt),
    .flush_cnt (s_flush_cnt)
  );

  function automatic logic [15:0] cf(input logic [95:0] d);
    return {8'hC3, d[7:0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive one cycle, record an accepted input as expected output
  task automatic step(input bit v, input logic [95:0] d, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = cf(d);
    out_ready = ordy;
    flush     = fl;
    #7;
    if (v && in_ready && !fl) sb_q.push_back('{d: d, c: cf(d)});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare presented output with the oldest expected entry
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      chk("out_valid_vs_sb", {127'd0, out_valid}, {127'd0, sb_q.size() != 0});
      if (!out_valid) begin
        chk("idle_ctrl_zero", {112'd0, out_ctrl}, 128'd0);
      end else if (sb_q.size() != 0) begin
        chk("out_data", {32'd0, out_data}, {32'd0, sb_q[0].d});
        chk("out_ctrl", {112'd0, out_ctrl}, {112'd0, sb_q[0].c});
        if (out_ready) void'(sb_q.pop_front());
      end
      if (flush) sb_q.delete();
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_data = 96'h55; in_ctrl = 16'h00ff; out_ready = 1'b0;

    // Reset held three cycles with a pending input
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_ctrl", {112'd0, out_ctrl}, 128'd0);
      chk("rst_stall_cnt", {112'd0, stall_cnt}, 128'd0);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("post_rst_out_data", {32'd0, out_data}, 128'd0);
    chk("post_rst_flush_cnt", {112'd0, flush_cnt}, 128'd0);
    @(posedge clk);
    #1;

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 96'h10 + 96'(i), 1'b1, 1'b0);
      chk("stream_valid", {127'd0, out_valid}, 128'd1);
      chk("stream_data", {32'd0, out_data}, 128'h10 + 128'(i));
    end
    step(1'b0, 96'h0, 1'b1, 1'b0);
    chk("stream_stall_cnt", {112'd0, stall_cnt}, 128'd0);

    // Back-pressure into the skid slot, then release
    step(1'b1, 96'hA0, 1'b1, 1'b0);
    step(1'b1, 96'hA1, 1'b0, 1'b0);
    chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    chk("bp_hold_a0", {32'd0, out_data}, 128'hA0);
    step(1'b1, 96'hA2, 1'b0, 1'b0);
    step(1'b1, 96'hA2, 1'b0, 1'b0);
    chk("bp_stall_cnt", {112'd0, stall_cnt}, 128'd3);
    chk("bp_hold_a0_again", {32'd0, out_data}, 128'hA0);
    step(1'b1, 96'hA2, 1'b1, 1'b0);
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
    chk("bp_skid_to_main", {32'd0, out_data}, 128'hA1);
    step(1'b1, 96'hA2, 1'b1, 1'b0);
    step(1'b0, 96'h0, 1'b1, 1'b0);
    chk("bp_stall_final", {112'd0, stall_cnt}, 128'd3);
    chk("bp_sat_stall", {126'd0, s_stall_cnt}, 128'd3);

    // Flush while FULL with an input offered
    step(1'b1, 96'hB0, 1'b1, 1'b0);
    step(1'b1, 96'hB1, 1'b0, 1'b0);
    step(1'b1, 96'hB2, 1'b0, 1'b1);
    chk("flush_full_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_full_ctrl", {112'd0, out_ctrl}, 128'd0);
    chk("flush_full_ready", {127'd0, in_ready}, 128'd1);
    chk("flush_full_cnt", {112'd0, flush_cnt}, 128'd3);
    chk("flush_full_data", {32'd0, out_data}, 128'hB0);
    chk("flush_full_stall", {112'd0, stall_cnt}, 128'd4);

    // Flush coinciding with a transfer out from BUSY
    step(1'b1, 96'hC0, 1'b1, 1'b0);
    step(1'b0, 96'h0, 1'b1, 1'b1);
    chk("flush_xfer_cnt", {112'd0, flush_cnt}, 128'd3);
    chk("flush_xfer_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_xfer_data", {32'd0, out_data}, 128'hC0);

    // Flush from BUSY, stalled, with an input offered: two entries lost
    step(1'b1, 96'hE0, 1'b1, 1'b0);
    step(1'b1, 96'hE1, 1'b0, 1'b1);
    chk("flush_busy_cnt", {112'd0, flush_cnt}, 128'd5);
    chk("flush_sat_cnt", {126'd0, s_flush_cnt}, 128'd3);

    // Long stall: narrow counter pins at all-ones
    step(1'b1, 96'hD0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 96'h0, 1'b0, 1'b0);
      chk("sat_stall_cnt", {126'd0, s_stall_cnt}, 128'd3);
    end
    chk("wide_stall_cnt", {112'd0, stall_cnt}, 128'd10);
    step(1'b0, 96'h0, 1'b1, 1'b0);
    step(1'b0, 96'h0, 1'b1, 1'b0);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
